// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch (IF)
// and the MEM stage (DM). DM has priority; a saturating starvation counter forces
// an IF win after STARVE_MAX consecutive lost arbitrations. Reads hold the port
// for MEM_LAT cycles, and the read data is returned to the requester that issued it.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,  // read issue -> data valid, >= 1
  parameter int STARVE_MAX = 4   // 1..15
) (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  // MEM-stage requester
  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  input  logic        dm_wen,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  // memory port
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic { IDLE, RD_WAIT } state_e;
  typedef enum logic { OWN_IF, OWN_DM } owner_e;

  localparam int            CW         = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAT_LOAD   = CW'(MEM_LAT);
  localparam logic [CW-1:0] LAT_LAST   = CW'(1);
  localparam logic [3:0]    STARVE_LIM = 4'(STARVE_MAX);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [CW-1:0] wait_q,  wait_d;
  logic [3:0]    starve_q, starve_d;

  logic final_wait;
  logic grant_ok;
  logic rd_grant;

  // Arbitration and memory-port drive: purely combinational from requests and state
  always_comb begin
    // NOTE: every output gets a default first, so no path through this block
    // leaves a signal unassigned and no latch is inferred.
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    // The final wait cycle frees the port, so a new grant can overlap the rvalid.
    final_wait = (state_q == RD_WAIT) && (wait_q == LAT_LAST);
    grant_ok   = !reset && ((state_q == IDLE) || final_wait);

    if (grant_ok) begin
      if (dm_req && !(if_req && (starve_q == STARVE_LIM))) begin
        dm_gnt    = 1'b1;
        mem_en    = 1'b1;
        mem_we    = dm_wen;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end else if (if_req) begin
        if_gnt    = 1'b1;
        mem_en    = 1'b1;
        mem_addr  = if_addr;
      end
    end

    rd_grant = if_gnt || (dm_gnt && !dm_wen);
  end

  // Read-return path: decoded from registered state only
  always_comb begin
    busy      = (state_q == RD_WAIT);
    if_rvalid = final_wait && (owner_q == OWN_IF);
    dm_rvalid = final_wait && (owner_q == OWN_DM);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    dm_rdata  = dm_rvalid ? mem_rdata : '0;
  end

  // Next-state: read-wait FSM, owner tracking and starvation counter
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wait_d   = wait_q;
    starve_d = starve_q;

    if (rd_grant) begin
      state_d = RD_WAIT;
      owner_d = if_gnt ? OWN_IF : OWN_DM;
      wait_d  = LAT_LOAD;
    end else if (final_wait) begin
      state_d = IDLE;
      wait_d  = '0;
    end else if (state_q == RD_WAIT) begin
      wait_d  = wait_q - LAT_LAST;
    end

    // A dropped IF request (flush) restarts the fairness window.
    if (!if_req || if_gnt) begin
      starve_d = '0;
    end else if (dm_gnt && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      wait_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wait_q   <= wait_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a MEM_LAT=2 instance driven from a vector table,
// and a MEM_LAT=1 instance exercised with hand-written starvation sequences.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_wen;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        if_gnt;
    logic        dm_gnt;
    logic        if_rvalid;
    logic        dm_rvalid;
    logic        mem_en;
    logic        mem_we;
    logic        busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] rdata;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        dm_req = 1'b0;
  logic [31:0] dm_addr = '0;
  logic        dm_wen = 1'b0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] mem_rdata = '0;

  logic        if_gnt2, if_rvalid2, dm_gnt2, dm_rvalid2, mem_en2, mem_we2, busy2;
  logic [31:0] if_rdata2, dm_rdata2, mem_addr2, mem_wdata2;
  logic        if_gnt1, if_rvalid1, dm_gnt1, dm_rvalid1, mem_en1, mem_we1, busy1;
  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut2 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt2), .if_rvalid(if_rvalid2),
    .if_rdata(if_rdata2),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_wen(dm_wen), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt2), .dm_rvalid(dm_rvalid2), .dm_rdata(dm_rdata2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata), .busy(busy2)
  );

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1),
    .if_rdata(if_rdata1),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_wen(dm_wen), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt1), .dm_rvalid(dm_rvalid1), .dm_rdata(dm_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata), .busy(busy1)
  );

  function automatic in_t mk_in(logic rst, logic ir, logic [31:0] ia, logic dr, logic dw,
                                logic [31:0] da, logic [31:0] dwd, logic [31:0] mr);
    in_t v;
    v = '{rst, ir, ia, dr, dw, da, dwd, mr};
    return v;
  endfunction

  function automatic exp_t mk_exp(logic ig, logic dg, logic irv, logic drv, logic en,
                                  logic we, logic bz, logic [31:0] ma, logic [31:0] mw,
                                  logic [31:0] rd);
    exp_t e;
    e = '{ig, dg, irv, drv, en, we, bz, ma, mw, rd};
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge; outputs settle before the next rise.
  task automatic apply(input in_t v);
    @(negedge clk);
    reset     = v.rst;
    if_req    = v.if_req;
    if_addr   = v.if_addr;
    dm_req    = v.dm_req;
    dm_wen    = v.dm_wen;
    dm_addr   = v.dm_addr;
    dm_wdata  = v.dm_wdata;
    mem_rdata = v.mem_rdata;
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    exp_t act;
    logic mask;
    logic [3:0] exp_bits;

    // ---------------- MEM_LAT=2 vector table ----------------
    // reset state
    vecs.push_back('{mk_in(1,0,0,0,0,0,0,0),              mk_exp(0,0,0,0,0,0,0,0,0,0)});
    // IF read alone at 0x100; held request must not get a second grant while busy
    vecs.push_back('{mk_in(0,1,32'h100,0,0,0,0,0),        mk_exp(1,0,0,0,1,0,0,32'h100,0,0)});
    vecs.push_back('{mk_in(0,1,32'h104,0,0,0,0,0),        mk_exp(0,0,0,0,0,0,1,0,0,0)});
    vecs.push_back('{mk_in(0,0,0,0,0,0,0,32'hA5A50001),   mk_exp(0,0,1,0,0,0,1,0,0,32'hA5A50001)});
    vecs.push_back('{mk_in(0,0,0,0,0,0,0,0),              mk_exp(0,0,0,0,0,0,0,0,0,0)});
    // IF and DM load together: DM first, IF granted in DM's final wait cycle
    vecs.push_back('{mk_in(0,1,32'h300,1,0,32'h2000,0,0), mk_exp(0,1,0,0,1,0,0,32'h2000,0,0)});
    vecs.push_back('{mk_in(0,1,32'h300,0,0,0,0,0),        mk_exp(0,0,0,0,0,0,1,0,0,0)});
    vecs.push_back('{mk_in(0,1,32'h300,0,0,0,0,32'h11112222),
                     mk_exp(1,0,0,1,1,0,1,32'h300,0,32'h11112222)});
    vecs.push_back('{mk_in(0,0,0,0,0,0,0,0),              mk_exp(0,0,0,0,0,0,1,0,0,0)});
    vecs.push_back('{mk_in(0,0,0,0,0,0,0,32'h33334444),   mk_exp(0,0,1,0,0,0,1,0,0,32'h33334444)});
    vecs.push_back('{mk_in(0,0,0,0,0,0,0,0),              mk_exp(0,0,0,0,0,0,0,0,0,0)});
    // store to 0x40 then IF read next cycle
    vecs.push_back('{mk_in(0,1,32'h500,1,1,32'h40,32'hDEADBEEF,0),
                     mk_exp(0,1,0,0,1,1,0,32'h40,32'hDEADBEEF,0)});
    vecs.push_back('{mk_in(0,1,32'h500,0,0,0,0,0),        mk_exp(1,0,0,0,1,0,0,32'h500,0,0)});
    vecs.push_back('{mk_in(0,0,0,0,0,0,0,0),              mk_exp(0,0,0,0,0,0,1,0,0,0)});
    vecs.push_back('{mk_in(0,0,0,0,0,0,0,32'h55556666),   mk_exp(0,0,1,0,0,0,1,0,0,32'h55556666)});
    // back-to-back stores, one per cycle
    vecs.push_back('{mk_in(0,0,0,1,1,32'h44,32'h1,0),     mk_exp(0,1,0,0,1,1,0,32'h44,32'h1,0)});
    vecs.push_back('{mk_in(0,0,0,1,1,32'h48,32'h2,0),     mk_exp(0,1,0,0,1,1,0,32'h48,32'h2,0)});
    vecs.push_back('{mk_in(0,0,0,0,0,0,0,0),              mk_exp(0,0,0,0,0,0,0,0,0,0)});
    // reset mid-read: no rvalid, idle and grantable right after
    vecs.push_back('{mk_in(0,1,32'h600,0,0,0,0,0),        mk_exp(1,0,0,0,1,0,0,32'h600,0,0)});
    vecs.push_back('{mk_in(1,0,0,0,0,0,0,0),              mk_exp(0,0,0,0,0,0,1,0,0,0)});
    vecs.push_back('{mk_in(0,1,32'h700,0,0,0,0,32'h9999), mk_exp(1,0,0,0,1,0,0,32'h700,0,0)});
    vecs.push_back('{mk_in(0,0,0,0,0,0,0,0),              mk_exp(0,0,0,0,0,0,1,0,0,0)});
    vecs.push_back('{mk_in(0,0,0,0,0,0,0,32'h7777),       mk_exp(0,0,1,0,0,0,1,0,0,32'h7777)});
    vecs.push_back('{mk_in(0,0,0,0,0,0,0,0),              mk_exp(0,0,0,0,0,0,0,0,0,0)});

    for (int n = 0; n < vecs.size(); n++) begin
      apply(vecs[n].i);
      // Address/data are only meaningful with mem_en (and forced to 0 in reset);
      // rdata only with the matching rvalid.
      mask = vecs[n].e.mem_en || vecs[n].i.rst;
      act.if_gnt    = if_gnt2;
      act.dm_gnt    = dm_gnt2;
      act.if_rvalid = if_rvalid2;
      act.dm_rvalid = dm_rvalid2;
      act.mem_en    = mem_en2;
      act.mem_we    = mask ? mem_we2 : 1'b0;
      act.busy      = busy2;
      act.mem_addr  = mask ? mem_addr2 : '0;
      act.mem_wdata = mask ? mem_wdata2 : '0;
      act.rdata     = vecs[n].e.if_rvalid ? if_rdata2 :
                      vecs[n].e.dm_rvalid ? dm_rdata2 : '0;
      check($sformatf("vec%0d", n), 128'(act), 128'(vecs[n].e));
    end

    // ---------------- MEM_LAT=1 starvation ----------------
    // bits: {if_gnt, dm_gnt, if_rvalid, dm_rvalid}
    apply(mk_in(1,0,0,0,0,0,0,0));
    for (int k = 0; k < 6; k++) begin
      apply(mk_in(0,1,32'h800,1,0,32'h3000 + 32'(k),0,32'hC0DE0000 + 32'(k)));
      case (k)
        0:       exp_bits = 4'b0100;
        4:       exp_bits = 4'b1001;
        5:       exp_bits = 4'b0110;
        default: exp_bits = 4'b0101;
      endcase
      check($sformatf("starve_k%0d", k), 128'({if_gnt1, dm_gnt1, if_rvalid1, dm_rvalid1}),
            128'(exp_bits));
      if (k == 1)
        check("starve_dm_rdata", 128'(dm_rdata1), 128'(32'hC0DE0001));
      if (k == 5)
        check("starve_if_rdata", 128'(if_rdata1), 128'(32'hC0DE0005));
    end
    check("lat1_busy", 128'(busy1), 128'(1'b1));

    // ---------------- withdrawal clears the starvation count ----------------
    // bits: {if_gnt, dm_gnt}; two DM wins, IF drops once, then four more DM wins
    apply(mk_in(1,0,0,0,0,0,0,0));
    for (int k = 0; k < 8; k++) begin
      apply(mk_in(0, (k != 2), 32'h900, 1, 0, 32'h4000, 0, 0));
      exp_bits = (k == 7) ? 4'b0010 : 4'b0001;
      check($sformatf("withdraw_k%0d", k), 128'({if_gnt1, dm_gnt1}), 128'(exp_bits));
    end

    apply(mk_in(1,0,0,0,0,0,0,0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
